// File: rtl/usr_cmd_sched_if.sv
// Command/response bundle between two requesters, the scheduler and the shared USR.
// slave is the scheduler's view; master is the environment (requesters, USR, response sink).
interface usr_cmd_sched_if #(
   parameter int WIDTH = 4,
   parameter int AMT_W = 3
);
   logic             a_valid;
   logic             a_ready;
   logic [1:0]       a_op;
   logic [AMT_W-1:0] a_amt;
   logic [WIDTH-1:0] a_data;

   logic             b_valid;
   logic             b_ready;
   logic [1:0]       b_op;
   logic [AMT_W-1:0] b_amt;
   logic [WIDTH-1:0] b_data;

   logic [1:0]       usr_mode;
   logic [WIDTH-1:0] usr_din;
   logic [WIDTH-1:0] usr_q;

   logic             rsp_valid;
   logic             rsp_id;
   logic [WIDTH-1:0] rsp_data;
   logic             busy;

   modport slave (
      input  a_valid, a_op, a_amt, a_data,
      input  b_valid, b_op, b_amt, b_data,
      input  usr_q,
      output a_ready, b_ready,
      output usr_mode, usr_din,
      output rsp_valid, rsp_id, rsp_data, busy
   );

   modport master (
      output a_valid, a_op, a_amt, a_data,
      output b_valid, b_op, b_amt, b_data,
      output usr_q,
      input  a_ready, b_ready,
      input  usr_mode, usr_din,
      input  rsp_valid, rsp_id, rsp_data, busy
   );
endinterface

// File: rtl/usr_cmd_sched.sv
// Round-robin scheduler granting one of two requesters exclusive use of a 4-bit universal
// shift register; drives its mode/data lines and returns the final contents to the winner.
module usr_cmd_sched #(
   parameter int WIDTH = 4,
   parameter int AMT_W = 3
) (
   input  logic           clk,
   input  logic           rst,
   usr_cmd_sched_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      LOAD  = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [1:0]       OP_HOLD = 2'b00;
   localparam logic [1:0]       OP_LOAD = 2'b11;
   localparam logic [AMT_W-1:0] AMT_MAX = AMT_W'(WIDTH);
   localparam logic [AMT_W-1:0] AMT_ONE = AMT_W'(1);

   state_t           state_q, state_d;
   logic             last_b_q, last_b_d;
   logic [1:0]       op_q, op_d;
   logic [AMT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             id_q, id_d;

   logic [1:0]       usr_mode_q, usr_mode_d;
   logic [WIDTH-1:0] usr_din_q, usr_din_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic             rsp_id_q, rsp_id_d;
   logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
   logic             busy_q, busy_d;

   logic             grant_a, grant_b, accept;
   logic [1:0]       win_op;
   logic [AMT_W-1:0] raw_amt, win_amt;
   logic [WIDTH-1:0] win_data;

   // last_b_q records the previous winner; resetting it to B makes A win the first tie.
   always_comb begin
      grant_a = 1'b0;
      grant_b = 1'b0;
      if (!rst && state_q == IDLE) begin
         if (bus.a_valid && (!bus.b_valid || last_b_q)) begin
            grant_a = 1'b1;
         end else if (bus.b_valid) begin
            grant_b = 1'b1;
         end
      end
   end

   assign accept   = grant_a | grant_b;
   assign win_op   = grant_b ? bus.b_op   : bus.a_op;
   assign raw_amt  = grant_b ? bus.b_amt  : bus.a_amt;
   assign win_data = grant_b ? bus.b_data : bus.a_data;
   assign win_amt  = (raw_amt > AMT_MAX) ? AMT_MAX : raw_amt;

   // State register and latched command.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         last_b_q <= 1'b1;
         op_q     <= OP_HOLD;
         cnt_q    <= '0;
         data_q   <= '0;
         id_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         last_b_q <= last_b_d;
         op_q     <= op_d;
         cnt_q    <= cnt_d;
         data_q   <= data_d;
         id_q     <= id_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (win_op == OP_LOAD) begin
                  state_d = LOAD;
               end else if (win_op != OP_HOLD && win_amt != '0) begin
                  state_d = SHIFT;
               end else begin
                  state_d = DONE;
               end
            end
         end
         SHIFT: begin
            if (cnt_q <= AMT_ONE) begin
               state_d = DONE;
            end
         end
         LOAD:    state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      last_b_d = last_b_q;
      op_d     = op_q;
      cnt_d    = cnt_q;
      data_d   = data_q;
      id_d     = id_q;
      if (accept) begin
         last_b_d = grant_b;
         op_d     = win_op;
         cnt_d    = win_amt;
         data_d   = win_data;
         id_d     = grant_b;
      end else if (state_q == SHIFT) begin
         cnt_d = cnt_q - AMT_ONE;
      end
   end

   // Outputs are registered from the upcoming state, so they line up with the state itself.
   always_comb begin
      usr_mode_d  = OP_HOLD;
      usr_din_d   = '0;
      rsp_valid_d = 1'b0;
      rsp_id_d    = rsp_id_q;
      rsp_data_d  = rsp_data_q;
      busy_d      = (state_d != IDLE);
      case (state_d)
         SHIFT: usr_mode_d = op_d;
         LOAD: begin
            usr_mode_d = OP_LOAD;
            usr_din_d  = data_d;
         end
         default: usr_mode_d = OP_HOLD;
      endcase
      // usr_q already holds the last update by the end of DONE.
      if (state_q == DONE) begin
         rsp_valid_d = 1'b1;
         rsp_id_d    = id_q;
         rsp_data_d  = bus.usr_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         usr_mode_q  <= OP_HOLD;
         usr_din_q   <= '0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= 1'b0;
         rsp_data_q  <= '0;
         busy_q      <= 1'b0;
      end else begin
         usr_mode_q  <= usr_mode_d;
         usr_din_q   <= usr_din_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_id_q    <= rsp_id_d;
         rsp_data_q  <= rsp_data_d;
         busy_q      <= busy_d;
      end
   end

   assign bus.a_ready   = grant_a;
   assign bus.b_ready   = grant_b;
   assign bus.usr_mode  = usr_mode_q;
   assign bus.usr_din   = usr_din_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_id    = rsp_id_q;
   assign bus.rsp_data  = rsp_data_q;
   assign bus.busy      = busy_q;

endmodule
